// File: rtl/pr_softreg_if.sv
// SoftReg request/response bundle between the host sequencer and the PageRank core.
// Requests are single-cycle pulses; responses arrive later as a one-cycle strobe.
interface pr_softreg_if;
    logic        req_valid;
    logic        req_isWrite;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid;
    logic [63:0] resp_data;

    modport master (
        output req_valid, req_isWrite, req_addr, req_data,
        input  resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_isWrite, req_addr, req_data,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/pr_softreg_host.sv
// Host-side SoftReg sequencer: programs the PageRank configuration registers,
// then polls DONE_ALL until completion or until the cycle budget runs out.
module pr_softreg_host #(
    parameter logic [63:0] N_VERT_VAL    = 64'd1000,
    parameter logic [63:0] N_INEDGES_VAL = 64'd5508,
    parameter logic [63:0] VADDR_VAL     = 64'd0,
    parameter logic [63:0] IEADDR_VAL    = 64'd16000,
    parameter logic [63:0] WADDR0_VAL    = 64'd60064,
    parameter logic [63:0] WADDR1_VAL    = 64'd68064,
    parameter logic [63:0] N_ROUNDS_VAL  = 64'd10,
    parameter int          POLL_GAP      = 1024,
    parameter int          TIMEOUT_CYC   = 500000,
    parameter logic [31:0] ADDR_N_VERT      = 32'h0000_0000,
    parameter logic [31:0] ADDR_N_INEDGES   = 32'h0000_0008,
    parameter logic [31:0] ADDR_VADDR       = 32'h0000_0010,
    parameter logic [31:0] ADDR_IEADDR      = 32'h0000_0018,
    parameter logic [31:0] ADDR_WRITE_ADDR0 = 32'h0000_0020,
    parameter logic [31:0] ADDR_WRITE_ADDR1 = 32'h0000_0028,
    parameter logic [31:0] ADDR_N_ROUNDS    = 32'h0000_0030,
    parameter logic [31:0] ADDR_DONE_PARAMS = 32'h0000_0038,
    parameter logic [31:0] ADDR_DONE_ALL    = 32'h0000_0040
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    pr_softreg_if.master        softreg,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [63:0]         result,
    output logic [31:0]         cycles
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_GAP       = 3'd2;
    localparam logic [2:0] S_POLL_REQ  = 3'd3;
    localparam logic [2:0] S_POLL_WAIT = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_TIMEOUT   = 3'd6;

    localparam int          GW          = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int          GAP_LAST_I  = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LAST_I);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYC);
    localparam logic [2:0]  AFTER_POLL  = (POLL_GAP == 0) ? S_POLL_REQ : S_GAP;

    logic [2:0]    state;
    logic [2:0]    idx;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   cnt;
    logic [31:0]   cnt_next;
    logic          resp_ok;
    logic          expire;
    logic          idle_like;

    function automatic logic [31:0] write_addr(input logic [2:0] i);
        case (i)
            3'd0:    write_addr = ADDR_N_VERT;
            3'd1:    write_addr = ADDR_N_INEDGES;
            3'd2:    write_addr = ADDR_VADDR;
            3'd3:    write_addr = ADDR_IEADDR;
            3'd4:    write_addr = ADDR_WRITE_ADDR0;
            3'd5:    write_addr = ADDR_WRITE_ADDR1;
            3'd6:    write_addr = ADDR_N_ROUNDS;
            default: write_addr = ADDR_DONE_PARAMS;
        endcase
    endfunction

    function automatic logic [63:0] write_data(input logic [2:0] i);
        case (i)
            3'd0:    write_data = N_VERT_VAL;
            3'd1:    write_data = N_INEDGES_VAL;
            3'd2:    write_data = VADDR_VAL;
            3'd3:    write_data = IEADDR_VAL;
            3'd4:    write_data = WADDR0_VAL;
            3'd5:    write_data = WADDR1_VAL;
            3'd6:    write_data = N_ROUNDS_VAL;
            default: write_data = 64'd0;
        endcase
    endfunction

    // A response landing in the same cycle as our read pulse belongs to no read of ours.
    assign resp_ok   = softreg.resp_valid && !softreg.req_valid;
    assign cnt_next  = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    assign expire    = (TIMEOUT_CYC != 0) && (cnt_next == TIMEOUT_LIM);
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            idx                 <= 3'd0;
            gap_cnt             <= '0;
            cnt                 <= 32'd0;
            busy                <= 1'b0;
            done                <= 1'b0;
            timeout             <= 1'b0;
            result              <= 64'd0;
            cycles              <= 32'd0;
            softreg.req_valid   <= 1'b0;
            softreg.req_isWrite <= 1'b0;
            softreg.req_addr    <= 32'd0;
            softreg.req_data    <= 64'd0;
        end else begin
            softreg.req_valid   <= 1'b0;
            softreg.req_isWrite <= 1'b0;
            softreg.req_addr    <= 32'd0;
            softreg.req_data    <= 64'd0;
            if (idle_like) begin
                if (start) begin
                    busy                <= 1'b1;
                    done                <= 1'b0;
                    timeout             <= 1'b0;
                    result              <= 64'd0;
                    cycles              <= 32'd0;
                    cnt                 <= 32'd0;
                    idx                 <= 3'd1;
                    state               <= S_WRITE;
                    softreg.req_valid   <= 1'b1;
                    softreg.req_isWrite <= 1'b1;
                    softreg.req_addr    <= write_addr(3'd0);
                    softreg.req_data    <= write_data(3'd0);
                end
            end else begin
                cnt <= cnt_next;
                // Completion is checked before expiry so a coincident answer still counts.
                if (state == S_POLL_WAIT && resp_ok && softreg.resp_data != 64'd0) begin
                    result <= softreg.resp_data;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    cycles <= cnt_next;
                    state  <= S_DONE;
                end else if (expire) begin
                    timeout <= 1'b1;
                    busy    <= 1'b0;
                    cycles  <= cnt_next;
                    state   <= S_TIMEOUT;
                end else begin
                    case (state)
                        S_WRITE: begin
                            softreg.req_valid   <= 1'b1;
                            softreg.req_isWrite <= 1'b1;
                            softreg.req_addr    <= write_addr(idx);
                            softreg.req_data    <= write_data(idx);
                            idx                 <= idx + 3'd1;
                            gap_cnt             <= '0;
                            if (idx == 3'd7) state <= AFTER_POLL;
                        end
                        S_GAP: begin
                            gap_cnt <= gap_cnt + 1'b1;
                            if (gap_cnt == GAP_LAST) state <= S_POLL_REQ;
                        end
                        S_POLL_REQ: begin
                            softreg.req_valid <= 1'b1;
                            softreg.req_addr  <= ADDR_DONE_ALL;
                            state             <= S_POLL_WAIT;
                        end
                        S_POLL_WAIT: begin
                            gap_cnt <= '0;
                            if (resp_ok) state <= AFTER_POLL;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pr_softreg_host.sv
// Self-checking bench for pr_softreg_host: scoreboard of expected SoftReg requests
// plus directed checks of status outputs, using a DONE_ALL responder stub.
module tb_pr_softreg_host;

    localparam int GAP = 4;
    localparam int TO  = 100;
    localparam logic [31:0] DONE_ALL_ADDR = 32'h40;

    typedef struct {
        int          edge_no;
        logic        is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, timeout;
    logic [63:0] result;
    logic [31:0] cycles;

    logic        stub_valid = 1'b0, stray_valid = 1'b0;
    logic [63:0] stub_data = 64'd0, stray_data = 64'd0;
    logic        stub_en = 1'b0;
    int          stub_wait = 0;
    logic        stub_drop = 1'b0;
    logic [63:0] stub_q[$];

    req_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] w_addr [8] = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30, 32'h38};
    logic [63:0] w_data [8] = '{64'd1000, 64'd5508, 64'd0, 64'd16000, 64'd60064, 64'd68064, 64'd10, 64'd0};

    pr_softreg_if sif ();

    assign sif.resp_valid = stub_valid | stray_valid;
    assign sif.resp_data  = stub_valid ? stub_data : stray_data;

    pr_softreg_host #(.POLL_GAP(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .softreg (sif),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .result  (result),
        .cycles  (cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Requests are seen here one negedge after the edge that registered them.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.req_valid) begin
                check("req_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_edge",    64'(cyc), 64'(e.edge_no));
                    check("req_isWrite", 64'(sif.req_isWrite), 64'(e.is_write));
                    check("req_addr",    64'(sif.req_addr), 64'(e.addr));
                    check("req_data",    sif.req_data, e.data);
                end
            end else begin
                check("idle_fields", 64'({sif.req_isWrite, |sif.req_addr, |sif.req_data}), 64'd0);
            end
        end
    end

    // DONE_ALL responder: answers a read three edges after it was issued.
    always @(negedge clk) begin
        if (stub_drop) begin
            stub_valid = 1'b0;
            stub_data  = 64'd0;
            stub_drop  = 1'b0;
        end
        if (stub_wait > 0) begin
            stub_wait--;
            if (stub_wait == 0) begin
                stub_valid = 1'b1;
                stub_data  = stub_q.pop_front();
                stub_drop  = 1'b1;
            end
        end
        if (stub_en && !rst && sif.req_valid && !sif.req_isWrite && stub_q.size() != 0)
            stub_wait = 2;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic push_req(input int e, input logic w, input logic [31:0] a, input logic [63:0] d);
        req_t r;
        r.edge_no = e;
        r.is_write = w;
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
    endtask

    task automatic applyStimulus(output int t, input logic hold);
        t = cyc + 1;
        for (int i = 0; i < 8; i++) push_req(t + i, 1'b1, w_addr[i], w_data[i]);
        push_req(t + 8 + GAP, 1'b0, DONE_ALL_ADDR, 64'd0);
        start = 1'b1;
        step(1);
        if (!hold) start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic b, input logic d, input logic to,
                               input logic [63:0] res, input logic [31:0] cyc_v);
        check({tag, "_busy"},    64'(busy), 64'(b));
        check({tag, "_done"},    64'(done), 64'(d));
        check({tag, "_timeout"}, 64'(timeout), 64'(to));
        check({tag, "_result"},  result, res);
        check({tag, "_cycles"},  64'(cycles), 64'(cyc_v));
    endtask

    initial begin
        int t;
        @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
        check("reset_req_valid", 64'(sif.req_valid), 64'd0);
        rst = 1'b0;
        step(2);

        // Program, poll twice (0 then 0x2A), complete.
        stub_q = '{64'd0, 64'h2A};
        stub_en = 1'b1;
        applyStimulus(t, 1'b0);
        push_req(t + 20, 1'b0, DONE_ALL_ADDR, 64'd0);
        check("accept_busy", 64'(busy), 64'd1);
        wait_edge(t + 22);
        checkOutput("pre_done", 1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
        wait_edge(t + 23);
        checkOutput("done", 1'b0, 1'b1, 1'b0, 64'h2A, 32'd23);
        step(3);
        check("q_empty_1", 64'(exp_q.size()), 64'd0);

        // Core never answers: budget expires.
        stub_en = 1'b0;
        applyStimulus(t, 1'b0);
        checkOutput("restart_clear", 1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
        wait_edge(t + 99);
        checkOutput("pre_timeout", 1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
        wait_edge(t + 100);
        checkOutput("timeout", 1'b0, 1'b0, 1'b1, 64'd0, 32'd100);
        step(5);
        check("q_empty_2", 64'(exp_q.size()), 64'd0);

        // Reset during the 4th write, then a clean restart.
        applyStimulus(t, 1'b0);
        wait_edge(t + 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req_valid", 64'(sif.req_valid), 64'd0);
        check("rst_req_addr",  64'(sif.req_addr), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_timeout",   64'(timeout), 64'd0);
        exp_q.delete();
        #1 rst = 1'b0;
        step(3);
        check("rst_idle_busy", 64'(busy), 64'd0);
        stub_q = '{64'h99};
        stub_en = 1'b1;
        applyStimulus(t, 1'b0);
        wait_edge(t + 15);
        checkOutput("after_rst", 1'b0, 1'b1, 1'b0, 64'h99, 32'd15);
        step(2);

        // Start held high while busy, stray response during the writes.
        stub_q = '{64'h55};
        applyStimulus(t, 1'b1);
        wait_edge(t + 2);
        stray_valid = 1'b1;
        stray_data  = 64'h5;
        step(1);
        stray_valid = 1'b0;
        stray_data  = 64'd0;
        wait_edge(t + 14);
        checkOutput("held_busy", 1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
        wait_edge(t + 15);
        checkOutput("held_done", 1'b0, 1'b1, 1'b0, 64'h55, 32'd15);
        start = 1'b0;
        step(5);
        check("held_done_stays", 64'(done), 64'd1);
        check("q_empty_3", 64'(exp_q.size()), 64'd0);

        // Answer arrives on exactly the expiry edge: completion wins.
        stub_en = 1'b0;
        applyStimulus(t, 1'b0);
        wait_edge(t + 99);
        stray_valid = 1'b1;
        stray_data  = 64'h77;
        step(1);
        stray_valid = 1'b0;
        stray_data  = 64'd0;
        checkOutput("coincide", 1'b0, 1'b1, 1'b0, 64'h77, 32'd100);
        step(3);
        check("q_empty_final", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
